op_downsample_queue: RTL and testbench

- Buffered, parametrised successor to the combinational op downsampler.
- Accepts up to NUM_IN ops per cycle, in lane order, into a DEPTH-entry circular FIFO.
- Drains up to NUM_OUT ops per cycle into a registered output stage, bounded by a dynamic limit and downstream backpressure.
- Sits between wide frontend stages (decode/rename) and narrower backend stages; absorbs width mismatch and bursts without stalling upstream until full.

---
 rtl/op_downsample_queue.sv | 134 +++++++++++++
 tb/tb_op_downsample_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/op_downsample_queue.sv
// Wide-in / narrow-out op queue: NUM_IN lanes enqueue into a DEPTH-entry circular
// FIFO that drains up to NUM_OUT ops per cycle into a registered output stage.
// Optional macro OP_DOWNSAMPLE_QUEUE_BYPASS_EN lets ops skip an empty FIFO.
module op_downsample_queue #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 2,
    parameter int OP_SIZE = 32,
    parameter int DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                IN_flush,
    input  logic [NUM_IN-1:0][OP_SIZE-1:0]      IN_ops,
    input  logic [NUM_IN-1:0]                   IN_opBaseValid,
    input  logic [NUM_IN-1:0]                   IN_opValid,
    output logic [NUM_IN-1:0]                   OUT_opStall,
    input  logic [$clog2(NUM_OUT+1)-1:0]        IN_dynMaxNumOut,
    input  logic                                IN_outStall,
    output logic [NUM_OUT-1:0][OP_SIZE-1:0]     OUT_ops,
    output logic [NUM_OUT-1:0]                  OUT_opsValid,
    output logic [$clog2(DEPTH+1)-1:0]          OUT_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(NUM_IN);

    logic [PW-1:0]                   rd_ptr_r;
    logic [PW-1:0]                   wr_ptr_r;
    logic [CW-1:0]                   count_r;
    logic [OP_SIZE-1:0]              mem_r [DEPTH];
    logic [NUM_IN-1:0]               accepted_s;
    logic [NUM_IN-1:0][OP_SIZE-1:0]  acc_ops_s;
    int                              num_acc_s;
    int                              pop_s;
    int                              byp_s;

    // Lane acceptance: candidates are ranked in lane order and take whatever
    // space the registered occupancy leaves; accepted ops are compacted by rank.
    always_comb begin
        int rank;
        int nacc;
        int free_slots;
        rank       = 0;
        nacc       = 0;
        free_slots = DEPTH - int'(count_r);
        accepted_s = '0;
        acc_ops_s  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (IN_opBaseValid[i] && IN_opValid[i]) begin
                rank = rank + 1;
                if (rank <= free_slots && !IN_flush) begin
                    accepted_s[i]            = 1'b1;
                    acc_ops_s[IW'(nacc)]     = IN_ops[i];
                    nacc                     = nacc + 1;
                end else begin
                    accepted_s[i] = 1'b0;
                end
            end else begin
                accepted_s[i] = 1'b0;
            end
        end
        num_acc_s   = nacc;
        OUT_opStall = IN_opBaseValid & ~accepted_s;
    end

    // Pop and bypass amounts for this cycle.
    always_comb begin
        int lim;
        lim   = (int'(IN_dynMaxNumOut) < NUM_OUT) ? int'(IN_dynMaxNumOut) : NUM_OUT;
        pop_s = 0;
        byp_s = 0;
        if (!IN_outStall && !IN_flush) begin
            pop_s = (int'(count_r) < lim) ? int'(count_r) : lim;
`ifdef OP_DOWNSAMPLE_QUEUE_BYPASS_EN
            if (count_r == CW'(0)) begin
                byp_s = (num_acc_s < lim) ? num_acc_s : lim;
            end else begin
                byp_s = 0;
            end
`endif
        end else begin
            pop_s = 0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst || IN_flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + PW'(pop_s);
            wr_ptr_r <= wr_ptr_r + PW'(num_acc_s - byp_s);
            count_r  <= count_r + CW'(num_acc_s - byp_s) - CW'(pop_s);
        end
    end

    // FIFO storage: accepted ops not taken by the bypass go in at wr_ptr.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_IN; k++) begin
            if (!rst && k >= byp_s && k < num_acc_s) begin
                mem_r[wr_ptr_r + PW'(k - byp_s)] <= acc_ops_s[k];
            end
        end
    end

    // Output-stage valids: held while downstream stalls, cleared by flush.
    always_ff @(posedge clk) begin
        if (rst || IN_flush) begin
            OUT_opsValid <= '0;
        end else if (!IN_outStall) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                OUT_opsValid[j] <= (j < pop_s + byp_s);
            end
        end
    end

    // Output-stage payload; lanes beyond the valid count carry don't-care data.
    always_ff @(posedge clk) begin
        if (!rst && !IN_flush && !IN_outStall) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (j < byp_s) begin
                    OUT_ops[j] <= acc_ops_s[j];
                end else begin
                    OUT_ops[j] <= mem_r[rd_ptr_r + PW'(j)];
                end
            end
        end
    end

    assign OUT_count = count_r;

endmodule

// File: tb/tb_op_downsample_queue.sv
// Self-checking bench for op_downsample_queue: directed plan steps followed by
// random traffic, all checked against a queue-based reference model.
module tb_op_downsample_queue;
    localparam int NUM_IN  = 4;
    localparam int NUM_OUT = 2;
    localparam int OP_SIZE = 32;
    localparam int DEPTH   = 8;

    logic                            clk;
    logic                            rst;
    logic                            flush;
    logic [NUM_IN-1:0][OP_SIZE-1:0]  ops;
    logic [NUM_IN-1:0]               bv;
    logic [NUM_IN-1:0]               v;
    logic [NUM_IN-1:0]               stall;
    logic [1:0]                      dyn;
    logic                            ostall;
    logic [NUM_OUT-1:0][OP_SIZE-1:0] out_ops;
    logic [NUM_OUT-1:0]              out_valid;
    logic [3:0]                      out_count;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] seq = 32'h100;

    // reference model state
    logic [OP_SIZE-1:0] mq[$];
    logic [OP_SIZE-1:0] m_out [NUM_OUT];
    logic [NUM_OUT-1:0] m_valid;

    op_downsample_queue #(
        .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .OP_SIZE(OP_SIZE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .IN_flush(flush),
        .IN_ops(ops),
        .IN_opBaseValid(bv),
        .IN_opValid(v),
        .OUT_opStall(stall),
        .IN_dynMaxNumOut(dyn),
        .IN_outStall(ostall),
        .OUT_ops(out_ops),
        .OUT_opsValid(out_valid),
        .OUT_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check stalls before the edge, advance the model, check outputs after.
    task automatic tick();
        int free_slots;
        int k;
        int lim;
        int n;
        logic [OP_SIZE-1:0] acc[$];
        logic [NUM_IN-1:0] exp_stall;
        #1;
        free_slots = DEPTH - mq.size();
        k = 0;
        exp_stall = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (bv[i]) begin
                if (v[i]) begin
                    k++;
                    if (k <= free_slots && !flush) acc.push_back(ops[i]);
                    else exp_stall[i] = 1'b1;
                end else begin
                    exp_stall[i] = 1'b1;
                end
            end
        end
        if (!rst) check("stall", 64'(stall), 64'(exp_stall));
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            m_valid = '0;
        end else begin
            if (!ostall) begin
                lim = (int'(dyn) > NUM_OUT) ? NUM_OUT : int'(dyn);
                n = (mq.size() < lim) ? mq.size() : lim;
                m_valid = '0;
`ifdef OP_DOWNSAMPLE_QUEUE_BYPASS_EN
                if (mq.size() == 0) begin
                    while (n < lim && acc.size() > 0) begin
                        m_out[n] = acc.pop_front();
                        m_valid[n] = 1'b1;
                        n++;
                    end
                    n = 0;
                end
`endif
                for (int j = 0; j < n; j++) begin
                    m_out[j] = mq.pop_front();
                    m_valid[j] = 1'b1;
                end
            end
            while (acc.size() > 0) mq.push_back(acc.pop_front());
        end
        #1;
        check("valid", 64'(out_valid), 64'(m_valid));
        check("count", 64'(out_count), 64'(mq.size()));
        for (int j = 0; j < NUM_OUT; j++) begin
            if (m_valid[j]) check("ops", 64'(out_ops[j]), 64'(m_out[j]));
        end
    endtask

    // Directed cycle with sequential op payloads.
    task automatic put(input logic [3:0] b, input logic [3:0] vv, input logic [1:0] d,
                       input logic os, input logic fl);
        for (int i = 0; i < NUM_IN; i++) begin
            ops[i] = seq;
            seq = seq + 32'd1;
        end
        bv = b; v = vv; dyn = d; ostall = os; flush = fl; rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bv = '0; v = '0; dyn = 2'd2; ostall = 1'b0; ops = '0;
        m_valid = '0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_count", 64'(out_count), 64'h0);

        // four ops in one cycle, drained two at a time
        put(4'b1111, 4'b1111, 2'd2, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) put(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // fill to 6 under stall, then offer four: lanes 2,3 stall
        put(4'b1111, 4'b1111, 2'd2, 1'b1, 1'b0);
        put(4'b0011, 4'b0011, 2'd2, 1'b1, 1'b0);
        put(4'b1111, 4'b1111, 2'd2, 1'b1, 1'b0);
        put(4'b1111, 4'b1111, 2'd2, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) put(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // valid hole in lane 2
        put(4'b1111, 4'b1011, 2'd2, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) put(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // count=5 with frozen output, then release one per cycle
        put(4'b0111, 4'b0111, 2'd2, 1'b0, 1'b0);
        put(4'b1111, 4'b1111, 2'd2, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) put(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
        for (int c = 0; c < 7; c++) put(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);

        // pointer wrap: 20 ops at 2 in / 2 out; dynMax=3 clamps to 2
        for (int c = 0; c < 10; c++) put(4'b0011, 4'b0011, 2'd3, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) put(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // flush with 7 queued and output stage valid; flush-cycle inputs dropped
        put(4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0);
        put(4'b1111, 4'b1111, 2'd0, 1'b0, 1'b0);
        put(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        put(4'b1111, 4'b1111, 2'd0, 1'b1, 1'b1);
        check("flush_count", 64'(out_count), 64'h0);
        check("flush_valid", 64'(out_valid), 64'h0);
        put(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_IN; i++) ops[i] = $urandom;
            bv     = 4'($urandom_range(0, 15));
            v      = 4'($urandom_range(0, 15));
            dyn    = 2'($urandom_range(0, 3));
            ostall = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 39) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
